dilated_tap_buffer: RTL

Multi-channel, parametrised history buffer that feeds the dilated causal convolution datapath. It keeps the last (K-1)*D+1 accepted input vectors and presents K taps spaced D samples apart, oldest first, together with a validity strobe. This successor to the fixed 4-entry shift buffer adds channels, dilation, variable tap count, an input-valid qualifier, a flush, and fill tracking.

---
 rtl/causal_conv_pkg.sv | 17 +
 rtl/dilated_delay_line.sv | 45 ++++
 rtl/dilated_tap_buffer.sv | 71 +++++++
 3 files changed

// File: rtl/causal_conv_pkg.sv
// Shared constants and sizing helpers for the dilated causal convolution path.
package causal_conv_pkg;

    // Element width used by the convolution datapath unless overridden.
    localparam int DEFAULT_W = 16;

    // Number of history entries needed to present K taps spaced D apart.
    function automatic int hist_len(input int k, input int d);
        return (k - 1) * d + 1;
    endfunction

    // Width of a counter that must hold values 0..l inclusive.
    function automatic int fill_width(input int l);
        return $clog2(l + 1);
    endfunction

endpackage

// File: rtl/dilated_delay_line.sv
// Single-channel history line: keeps the last L accepted samples and exposes
// K of them spaced D entries apart, oldest tap first.
module dilated_delay_line
    import causal_conv_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int K = 4,
    parameter int D = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           shift,
    input  logic [W-1:0]   sample,
    output logic [K*W-1:0] taps
);

    localparam int L = hist_len(K, D);

    // hist[L-1] is the newest entry, hist[0] the oldest.
    logic signed [W-1:0] hist [L];

    // Clear on reset/clear, otherwise shift left and append the new sample.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < L; i++) begin
                hist[i] <= '0;
            end
        end else if (shift) begin
            for (int i = 0; i < L - 1; i++) begin
                hist[i] <= hist[i + 1];
            end
            hist[L - 1] <= sample;
        end
    end

    // Taps are plain register reads, no logic between history and output.
    always_comb begin
        taps = '0;
        for (int k = 0; k < K; k++) begin
            taps[k*W +: W] = hist[k * D];
        end
    end

endmodule

// File: rtl/dilated_tap_buffer.sv
// Multi-channel dilated tap buffer: one delay line per channel sharing a single
// control path that tracks fill state and flags complete, freshly shifted tap sets.
module dilated_tap_buffer
    import causal_conv_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int C = 4,
    parameter int K = 4,
    parameter int D = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    inp_valid,
    input  logic [C*W-1:0]                          inp,
    input  logic                                    flush,
    output logic [K*C*W-1:0]                        out,
    output logic                                    out_valid,
    output logic [fill_width(hist_len(K, D))-1:0]   fill_level
);

    localparam int L  = hist_len(K, D);
    localparam int FW = fill_width(L);

    localparam logic [FW-1:0] FILL_FULL = FW'(L);
    localparam logic [FW-1:0] FILL_LAST = FW'(L - 1);

    // Flush outranks a same-cycle sample; the sample is dropped.
    logic shift;
    logic clr;

    assign clr   = flush;
    assign shift = inp_valid && !flush;

    logic [K*W-1:0] ch_taps [C];

    genvar c, k;
    generate
        for (c = 0; c < C; c++) begin : g_ch
            dilated_delay_line #(
                .W (W),
                .K (K),
                .D (D)
            ) u_line (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr),
                .shift  (shift),
                .sample (inp[c*W +: W]),
                .taps   (ch_taps[c])
            );

            for (k = 0; k < K; k++) begin : g_tap
                assign out[(k*C + c)*W +: W] = ch_taps[c][k*W +: W];
            end
        end
    endgenerate

    // Saturating fill counter and one-cycle strobe for a new, complete tap set.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fill_level <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= inp_valid && (fill_level >= FILL_LAST);
            if (inp_valid && (fill_level != FILL_FULL)) begin
                fill_level <= fill_level + FW'(1);
            end
        end
    end

endmodule
